// File: rtl/cacheline_burst_adaptor_if.sv
// Bundle of the cache-side pmem port and the memory-side burst port.
//   slave  : view used by the adaptor (responds to pmem, drives burst strobes)
//   master : view used by the surrounding cache and memory (drives requests and beats)
// Signals:
//   pmem_read/pmem_write/pmem_address/pmem_wdata  cache request and writeback line
//   pmem_rdata/pmem_resp                          fill line and one-cycle completion
//   burst_address/burst_read/burst_write/burst_wdata  burst request and write beat
//   burst_rdata/burst_resp                        read beat and per-beat handshake
interface cacheline_burst_adaptor_if #(
  parameter int unsigned s_line = 256,
  parameter int unsigned s_beat = 64
);
  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [s_line-1:0] pmem_wdata;
  logic [s_line-1:0] pmem_rdata;
  logic              pmem_resp;
  logic [31:0]       burst_address;
  logic              burst_read;
  logic              burst_write;
  logic [s_beat-1:0] burst_wdata;
  logic [s_beat-1:0] burst_rdata;
  logic              burst_resp;

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, burst_rdata, burst_resp,
    output pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
  );

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata, burst_rdata, burst_resp,
    input  pmem_rdata, pmem_resp, burst_address, burst_read, burst_write, burst_wdata
  );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Converts one cache line fill or writeback into a burst of s_line/s_beat beats
// (low beat first) and returns the assembled line / acknowledge with a one-cycle
// pmem_resp.
// Ports:
//   clk_i  system clock, rising edge
//   rst_i  synchronous active-high reset; abandons any burst in flight
//   bus    slave view of cacheline_burst_adaptor_if (pmem port + burst port)
// All outputs come straight from registers or from a mux on registered state, so
// there is no combinational path from burst_resp to any output.
module cacheline_burst_adaptor #(
  parameter int unsigned s_line   = 256,
  parameter int unsigned s_beat   = 64,
  parameter int unsigned s_offset = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  cacheline_burst_adaptor_if.slave  bus
);

  localparam int unsigned NumBeats = s_line / s_beat;
  localparam int unsigned CntW     = $clog2(NumBeats);
  localparam logic [CntW-1:0] LastBeat = CntW'(NumBeats - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [31-s_offset:0]   addr_q, addr_d;
  logic [s_line-1:0]      wline_q, wline_d;
  logic [s_line-1:0]      rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        // Write takes priority when both requests are raised together.
        if (bus.pmem_write) begin
          addr_d  = bus.pmem_address[31:s_offset];
          wline_d = bus.pmem_wdata;
          cnt_d   = '0;
          state_d = StWrite;
        end else if (bus.pmem_read) begin
          addr_d  = bus.pmem_address[31:s_offset];
          cnt_d   = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        if (bus.burst_resp) begin
          rdata_d[cnt_q*s_beat +: s_beat] = bus.burst_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) state_d = StDone;
        end
      end
      StWrite: begin
        if (bus.burst_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) state_d = StDone;
        end
      end
      StDone: begin
        // Requests are ignored here so the cache can drop them after pmem_resp.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.burst_read    = (state_q == StRead);
  assign bus.burst_write   = (state_q == StWrite);
  assign bus.pmem_resp     = (state_q == StDone);
  assign bus.pmem_rdata    = rdata_q;
  assign bus.burst_address = {addr_q, {s_offset{1'b0}}};
  // Only present a beat while writing so the bus idles at zero otherwise.
  assign bus.burst_wdata   = (state_q == StWrite) ? wline_q[cnt_q*s_beat +: s_beat] : '0;

endmodule
